alu: RTL and testbench



---
 rtl/alu.sv | 55 +++++
 tb/tb_alu.sv | 129 ++++++++++++
 2 files changed

// File: rtl/alu.sv
// Accumulator-style ALU for the VeriRISC-class datapath. The opcode type lives
// in package typedefs. The result is registered on the falling edge of clk.
package typedefs;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

endpackage

module alu
  import typedefs::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] data,
  input  opcode_t          opcode,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  // The default branch also covers X/Z on opcode, giving the accumulator through
  always_comb begin
    out_d = accum;
    case (opcode)
      ADD:     out_d = data + accum;
      AND:     out_d = data & accum;
      XOR:     out_d = data ^ accum;
      LDA:     out_d = data;
      default: out_d = accum;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign out  = out_q;
  assign zero = (accum == '0);

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: reset, every opcode, zero flag and
// rising/falling edge timing, with hand-computed expected values.
module tb_alu;
  import typedefs::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] accum;
  logic [7:0] data;
  opcode_t    opcode;
  logic [7:0] out;
  logic       zero;

  int unsigned n_cmp;
  int unsigned n_err;

  alu #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .accum  (accum),
    .data   (data),
    .opcode (opcode),
    .out    (out),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Drive just after a rising edge, confirm out holds until the falling edge,
  // then confirm the new value and that it is still there at the next rising edge.
  task automatic apply(input string tag, input opcode_t op, input logic [7:0] d,
                       input logic [7:0] a, input logic [7:0] exp_out,
                       input logic exp_zero);
    logic [7:0] prev;
    @(posedge clk);
    #1;
    prev   = out;
    opcode = op;
    data   = d;
    accum  = a;
    #1;
    check({tag, "_zero"}, {7'b0, zero}, {7'b0, exp_zero});
    check({tag, "_hold"}, out, prev);
    @(negedge clk);
    #1;
    check({tag, "_out"}, out, exp_out);
    @(posedge clk);
    #0;
    check({tag, "_stable"}, out, exp_out);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b1;
    accum  = 8'hDA;
    data   = 8'h37;
    opcode = ADD;

    // Let out take a non-zero value, then reset asynchronously mid-high-phase.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_reset", out, 8'h11);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_immediate", out, 8'h00);
    check("reset_zero", {7'b0, zero}, 8'h00);
    @(negedge clk);
    #1;
    check("reset_hold", out, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("release_wait", out, 8'h00);
    @(negedge clk);
    #1;
    check("release_first", out, 8'h11);

    apply("hlt",     HLT, 8'h37, 8'hDA, 8'hDA, 1'b0);
    apply("skz",     SKZ, 8'h37, 8'hDA, 8'hDA, 1'b0);
    apply("sto",     STO, 8'h37, 8'hDA, 8'hDA, 1'b0);
    apply("lda",     LDA, 8'h37, 8'hDA, 8'h37, 1'b0);
    apply("add",     ADD, 8'h37, 8'hDA, 8'h11, 1'b0);
    apply("and",     AND, 8'h37, 8'hDA, 8'h12, 1'b0);
    apply("xor",     XOR, 8'h37, 8'hDA, 8'hED, 1'b0);
    apply("add2",    ADD, 8'h07, 8'h12, 8'h19, 1'b0);
    apply("and2",    AND, 8'h1F, 8'h35, 8'h15, 1'b0);
    apply("xor2",    XOR, 8'h1E, 8'h1D, 8'h03, 1'b0);
    apply("jmp_z",   JMP, 8'h37, 8'h00, 8'h00, 1'b1);
    apply("lda_z",   LDA, 8'h72, 8'h00, 8'h72, 1'b1);
    apply("sto_nz",  STO, 8'h00, 8'h10, 8'h10, 1'b0);
    apply("add_max", ADD, 8'hFF, 8'h01, 8'h00, 1'b0);

    // Reset in the middle of a pending computation discards it.
    @(posedge clk);
    #1;
    opcode = XOR;
    data   = 8'hFF;
    accum  = 8'h0F;
    #2;
    rst_n = 1'b0;
    #1;
    check("midop_reset", out, 8'h00);
    @(negedge clk);
    #1;
    check("midop_hold", out, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("midop_after", out, 8'hF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
